turbo_enc_ctrl: RTL

Sequencing controller for the turbo encoder datapath. It accepts one code block of K bits and throttles the systematic input FIFO and both constituent encoders against FIFO full/empty status. It generates the QPP interleaver read address for the second encoder and runs trellis termination on encoder 1, then encoder 2. It sits between the block-level host interface and the encoder/FIFO datapath, and owns the `data_ready` enable and tail control of both encoders.

---
 rtl/turbo_enc_ctrl_pkg.sv | 23 ++
 rtl/turbo_enc_ctrl_if.sv | 42 ++++
 rtl/turbo_enc_ctrl_qpp.sv | 56 +++++
 rtl/turbo_enc_ctrl.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/turbo_enc_ctrl_pkg.sv
// turbo_pkg: shared constants and FSM state type for the turbo encoder
// sequencing controller.
//   K_MIN / K_MAX : legal code block size range
//   KW            : width of K and of interleaver addresses
//   TAIL_LEN      : trellis termination steps per constituent encoder
//   state_t       : controller FSM states
package turbo_pkg;

   localparam int K_MIN    = 40;
   localparam int K_MAX    = 6144;
   localparam int KW       = 13;
   localparam int TAIL_LEN = 3;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      RUN,
      TAIL1,
      TAIL2,
      DONE
   } state_t;

endpackage

// File: rtl/turbo_enc_ctrl_if.sv
// turbo_enc_ctrl_if: host and datapath signals of the turbo encoder controller.
//   blk_start/blk_k/f1/f2 : block start request and its configuration
//   in_empty/out_full     : systematic input FIFO and output FIFO status
//   in_rd                 : pop one bit from the systematic input FIFO
//   enc_en                : data_ready to both constituent encoders
//   enc1_term/enc2_term   : termination mode for encoder 1 / encoder 2
//   il_addr/il_vld        : interleaver read address and its valid strobe
//   busy/done/cfg_err     : block status towards the host
// Modports: master = host/datapath side, slave = controller side.
interface turbo_enc_ctrl_if #(
   parameter int KW = turbo_pkg::KW
);

   logic          blk_start;
   logic [KW-1:0] blk_k;
   logic [8:0]    f1;
   logic [9:0]    f2;
   logic          in_empty;
   logic          out_full;
   logic          in_rd;
   logic          enc_en;
   logic          enc1_term;
   logic          enc2_term;
   logic [KW-1:0] il_addr;
   logic          il_vld;
   logic          busy;
   logic          done;
   logic          cfg_err;

   modport master (
      output blk_start, blk_k, f1, f2, in_empty, out_full,
      input  in_rd, enc_en, enc1_term, enc2_term, il_addr, il_vld,
             busy, done, cfg_err
   );

   modport slave (
      input  blk_start, blk_k, f1, f2, in_empty, out_full,
      output in_rd, enc_en, enc1_term, enc2_term, il_addr, il_vld,
             busy, done, cfg_err
   );

endinterface

// File: rtl/turbo_enc_ctrl_qpp.sv
// qpp_addr_gen: QPP interleaver address generator.
// Produces pi(i) = (f1*i + f2*i^2) mod K incrementally without multipliers:
// pi advances by g, g advances by d = 2*f2 mod K, starting from
// pi(0)=0 and g(0)=(f1+f2) mod K.
//   clk, aclr : clock and asynchronous active-low reset
//   load      : initialise pi/g/d for a new block
//   adv       : step to the next address
//   k, f1, f2 : latched block configuration (f1, f2 < k)
//   pi        : current interleaver address
module qpp_addr_gen #(
   parameter int KW = 13
) (
   input  logic          clk,
   input  logic          aclr,
   input  logic          load,
   input  logic          adv,
   input  logic [KW-1:0] k,
   input  logic [KW-1:0] f1,
   input  logic [KW-1:0] f2,
   output logic [KW-1:0] pi
);

   logic [KW-1:0] g;
   logic [KW-1:0] d;

   // Both operands are already below m, so the sum is below 2m and a single
   // conditional subtract in KW+1 bits brings it back into range.
   function automatic logic [KW-1:0] mod_add(input logic [KW-1:0] a,
                                             input logic [KW-1:0] b,
                                             input logic [KW-1:0] m);
      logic [KW:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= {1'b0, m}) begin
         s = s - {1'b0, m};
      end
      return s[KW-1:0];
   endfunction

   // pi/g/d recurrence: load seeds the first difference terms, each advance
   // moves pi by the first difference and the first difference by the second.
   always_ff @(posedge clk or negedge aclr) begin
      if (!aclr) begin
         pi <= '0;
         g  <= '0;
         d  <= '0;
      end else if (load) begin
         pi <= '0;
         g  <= mod_add(f1, f2, k);
         d  <= mod_add(f2, f2, k);
      end else if (adv) begin
         pi <= mod_add(pi, g, k);
         g  <= mod_add(g, d, k);
      end
   end

endmodule

// File: rtl/turbo_enc_ctrl.sv
// turbo_enc_ctrl: sequencing controller for the turbo encoder datapath.
// Accepts one code block of K bits, throttles the systematic input FIFO and
// both constituent encoders against FIFO status, drives the QPP interleaver
// address for encoder 2 and runs trellis termination on encoder 1 then 2.
//   clk  : single clock, rising edge
//   aclr : asynchronous active-low reset
//   bus  : turbo_enc_ctrl_if.slave (host config/status + datapath strobes)
module turbo_enc_ctrl
   import turbo_pkg::*;
#(
   parameter int KW       = turbo_pkg::KW,
   parameter int TAIL_LEN = turbo_pkg::TAIL_LEN
) (
   input logic             clk,
   input logic             aclr,
   turbo_enc_ctrl_if.slave bus
);

   localparam int TW = $clog2(TAIL_LEN + 1);

   state_t        state;
   state_t        state_nxt;
   logic [KW-1:0] k_reg;
   logic [KW-1:0] f1_reg;
   logic [KW-1:0] f2_reg;
   logic [KW-1:0] bit_cnt;
   logic [TW-1:0] tail_cnt;
   logic [KW-1:0] pi;
   logic          cfg_ok;
   logic          start_ok;
   logic          bit_last;
   logic          tail_last;
   logic          step;
   logic          load;
   logic          in_rd;
   logic          enc_en;
   logic          enc1_term;
   logic          enc2_term;
   logic          cfg_err_q;

   assign cfg_ok = (bus.blk_k >= KW'(K_MIN)) && (bus.blk_k <= KW'(K_MAX)) &&
                   (bus.blk_k[2:0] == 3'd0) &&
                   (KW'(bus.f1) < bus.blk_k) && (KW'(bus.f2) < bus.blk_k);

   assign start_ok  = (state == IDLE) && bus.blk_start && cfg_ok;
   assign bit_last  = (bit_cnt == k_reg - KW'(1));
   assign tail_last = (tail_cnt == TW'(TAIL_LEN - 1));

   // Next-state and strobe decode. Strobes are combinational on the FIFO
   // status so a step and its pop/enable land in the same cycle; the term
   // flags stay high through stalls so the encoders never leave tail mode
   // early.
   always_comb begin
      state_nxt = state;
      step      = 1'b0;
      load      = 1'b0;
      in_rd     = 1'b0;
      enc_en    = 1'b0;
      enc1_term = 1'b0;
      enc2_term = 1'b0;
      case (state)
         IDLE: begin
            if (start_ok) begin
               state_nxt = LOAD;
            end
         end
         LOAD: begin
            load      = 1'b1;
            state_nxt = RUN;
         end
         RUN: begin
            step   = !bus.in_empty && !bus.out_full;
            in_rd  = step;
            enc_en = step;
            if (step && bit_last) begin
               state_nxt = TAIL1;
            end
         end
         TAIL1: begin
            step      = !bus.out_full;
            enc_en    = step;
            enc1_term = 1'b1;
            if (step && tail_last) begin
               state_nxt = TAIL2;
            end
         end
         TAIL2: begin
            step      = !bus.out_full;
            enc_en    = step;
            enc2_term = 1'b1;
            if (step && tail_last) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State, block configuration and progress counters. The configuration is
   // captured together with the accepted start because the host may change
   // blk_k/f1/f2 as soon as the request has been taken. The tail counter is
   // kept at zero outside the tail states so each tail phase starts fresh.
   always_ff @(posedge clk or negedge aclr) begin
      if (!aclr) begin
         state     <= IDLE;
         k_reg     <= '0;
         f1_reg    <= '0;
         f2_reg    <= '0;
         bit_cnt   <= '0;
         tail_cnt  <= '0;
         cfg_err_q <= 1'b0;
      end else begin
         state     <= state_nxt;
         cfg_err_q <= (state == IDLE) && bus.blk_start && !cfg_ok;
         if (start_ok) begin
            k_reg  <= bus.blk_k;
            f1_reg <= KW'(bus.f1);
            f2_reg <= KW'(bus.f2);
         end
         if (load) begin
            bit_cnt <= '0;
         end else if (in_rd) begin
            bit_cnt <= bit_cnt + KW'(1);
         end
         if ((state != TAIL1) && (state != TAIL2)) begin
            tail_cnt <= '0;
         end else if (step) begin
            tail_cnt <= tail_last ? '0 : tail_cnt + TW'(1);
         end
      end
   end

   qpp_addr_gen #(
      .KW(KW)
   ) u_qpp (
      .clk (clk),
      .aclr(aclr),
      .load(load),
      .adv (in_rd),
      .k   (k_reg),
      .f1  (f1_reg),
      .f2  (f2_reg),
      .pi  (pi)
   );

   assign bus.in_rd     = in_rd;
   assign bus.enc_en    = enc_en;
   assign bus.enc1_term = enc1_term;
   assign bus.enc2_term = enc2_term;
   assign bus.il_addr   = pi;
   assign bus.il_vld    = in_rd;
   assign bus.busy      = (state != IDLE);
   assign bus.done      = (state == DONE);
   assign bus.cfg_err   = cfg_err_q;

endmodule
